// File: rtl/astropix_spi_pkg.sv
// Shared SPI definitions for the AstroPix master and responder: FSM states,
// default idle fill byte and the MISO bit-pair selector.
package astropix_spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

  // Pair 0 is bits 7:6, pair 3 is bits 1:0.
  function automatic logic [1:0] pair_bits(input logic [7:0] b, input logic [1:0] idx);
    pair_bits = b[(3'd7 - {idx, 1'b0}) -: 2];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one history flop giving single-cycle rise/fall strobes.
// Latency: level 2 cycles, strobes 2 cycles after the input changes; no backpressure.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta  <= RESET_VAL;
      level <= RESET_VAL;
      prev  <= RESET_VAL;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/astropix_spi_responder.sv
// SPI responder: streams hit bytes (or the idle byte) as MISO bit pairs, collects MOSI config bytes.
// Latency: outputs registered one cycle after a synchronized SCK edge; hit source popped only on full-byte send.
module astropix_spi_responder
  import astropix_spi_pkg::*;
#(
  parameter bit         CPOL      = 1'b0,
  parameter bit         CPHA      = 1'b1,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_csb,
  input  logic       spi_clock,
  input  logic       spi_mosi,
  output logic       spi_miso0,
  output logic       spi_miso1,
  output logic       interruptB,
  input  logic [7:0] hit_data,
  input  logic       hit_valid,
  output logic       hit_ready,
  output logic [7:0] cfg_data,
  output logic       cfg_valid,
  output logic       frame_err,
  input  logic       err_clear
);

  spi_state_t state, state_nxt;
  logic       csb_s, csb_rise, csb_fall_unused;
  logic       sck_level_unused, sck_rise, sck_fall;
  logic       mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic       lead_evt, trail_evt, drive_evt, sample_evt, active;
  logic [1:0] settle;
  logic       armed;
  logic [7:0] tx_byte, tx_cur, rx_shift;
  logic       from_hit;
  logic [1:0] pair_cnt;
  logic [2:0] rx_bit_cnt;
  logic       frame_set;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_csb (
    .clock(clock), .reset(reset), .din(spi_csb),
    .level(csb_s), .rise(csb_rise), .fall(csb_fall_unused)
  );
  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sck (
    .clock(clock), .reset(reset), .din(spi_clock),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign lead_evt   = CPOL ? sck_fall : sck_rise;
  assign trail_evt  = CPOL ? sck_rise : sck_fall;
  assign drive_evt  = CPHA ? lead_evt : trail_evt;
  assign sample_evt = CPHA ? trail_evt : lead_evt;
  assign active     = (state == ST_SHIFT) && !csb_s;

  // A csb held low through reset must not restart a transfer: arm only once
  // the synchronizer carries real input and csb has been seen high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && csb_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (armed && !csb_s) state_nxt = ST_SHIFT;
      ST_SHIFT: if (csb_s)           state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  assign tx_cur = (pair_cnt == 2'd0) ? (hit_valid ? hit_data : IDLE_BYTE) : tx_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_byte   <= 8'h00;
      from_hit  <= 1'b0;
      pair_cnt  <= 2'd0;
      spi_miso0 <= 1'b0;
      spi_miso1 <= 1'b0;
      hit_ready <= 1'b0;
    end else begin
      hit_ready <= 1'b0;
      if (state == ST_IDLE) begin
        pair_cnt  <= 2'd0;
        spi_miso0 <= 1'b0;
        spi_miso1 <= 1'b0;
      end else if (active && drive_evt) begin
        if (pair_cnt == 2'd0) begin
          tx_byte  <= tx_cur;
          from_hit <= hit_valid;
        end
        {spi_miso0, spi_miso1} <= pair_bits(tx_cur, pair_cnt);
        hit_ready              <= (pair_cnt == 2'd3) && from_hit;
        pair_cnt               <= pair_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_shift   <= 8'h00;
      rx_bit_cnt <= 3'd0;
      cfg_data   <= 8'h00;
      cfg_valid  <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (state == ST_IDLE) begin
        rx_shift   <= 8'h00;
        rx_bit_cnt <= 3'd0;
      end else if (active && sample_evt) begin
        rx_shift   <= {rx_shift[6:0], mosi_s};
        rx_bit_cnt <= rx_bit_cnt + 3'd1;
        if (rx_bit_cnt == 3'd7) begin
          cfg_data  <= {rx_shift[6:0], mosi_s};
          cfg_valid <= 1'b1;
        end
      end
    end
  end

  assign frame_set = csb_rise && ((rx_bit_cnt != 3'd0) || (pair_cnt != 2'd0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      interruptB <= 1'b1;
    end else begin
      interruptB <= ~hit_valid;
      if (frame_set)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_astropix_spi_responder.sv
// Directed and randomized bench for astropix_spi_responder against a byte-level queue model.
module tb_astropix_spi_responder;
  localparam time HALF = 60;
  localparam logic [7:0] FILL = 8'hBC;

  logic       clock = 1'b0;
  logic       reset;
  logic       spi_csb, spi_clock, spi_mosi;
  logic       spi_miso0, spi_miso1, interruptB;
  logic [7:0] hit_data = 8'h00;
  logic       hit_valid = 1'b0;
  logic       hit_ready;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       frame_err;
  logic       err_clear;

  int errors = 0;
  int checks = 0;
  int hr_cnt = 0;

  logic [7:0] hit_q[$];
  logic [7:0] model_q[$];
  logic [7:0] cfg_got[$];
  logic [7:0] cfg_exp[$];
  logic [1:0] pairs_q[$];
  logic       mosi_q[$];

  astropix_spi_responder dut (
    .clock(clock), .reset(reset), .spi_csb(spi_csb), .spi_clock(spi_clock),
    .spi_mosi(spi_mosi), .spi_miso0(spi_miso0), .spi_miso1(spi_miso1),
    .interruptB(interruptB), .hit_data(hit_data), .hit_valid(hit_valid),
    .hit_ready(hit_ready), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .frame_err(frame_err), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  // First-word-fall-through hit source and cfg byte collector.
  always @(negedge clock) begin
    if (hit_ready === 1'b1) begin
      hr_cnt++;
      if (hit_q.size() != 0) void'(hit_q.pop_front());
    end
    if (cfg_valid === 1'b1) cfg_got.push_back(cfg_data);
    hit_valid = (hit_q.size() != 0);
    hit_data  = hit_valid ? hit_q[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_hit(input logic [7:0] b);
    hit_q.push_back(b);
    model_q.push_back(b);
  endtask

  task automatic push_mosi(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(b[i]);
    cfg_exp.push_back(b);
  endtask

  task automatic start_xfer();
    pairs_q.delete();
    spi_csb = 1'b0;
    #(HALF);
  endtask

  task automatic sck(input int n);
    for (int i = 0; i < n; i++) begin
      spi_clock = 1'b1;
      spi_mosi  = (mosi_q.size() != 0) ? mosi_q.pop_front() : 1'b0;
      #(HALF);
      pairs_q.push_back({spi_miso0, spi_miso1});
      spi_clock = 1'b0;
      #(HALF);
    end
  endtask

  task automatic end_xfer();
    spi_csb = 1'b1;
    #(2 * HALF);
  endtask

  // Each 4-pair group is one byte: the oldest unconsumed hit byte, else the fill byte.
  task automatic check_bytes(input string tag, input int nbytes);
    logic [7:0] got, exp;
    for (int b = 0; b < nbytes; b++) begin
      got = {pairs_q[4*b], pairs_q[4*b+1], pairs_q[4*b+2], pairs_q[4*b+3]};
      exp = (model_q.size() != 0) ? model_q.pop_front() : FILL;
      check($sformatf("%s_byte%0d", tag, b), {24'd0, got}, {24'd0, exp});
    end
  endtask

  task automatic check_cfg(input string tag);
    check($sformatf("%s_cfg_count", tag), cfg_got.size(), cfg_exp.size());
    for (int i = 0; i < cfg_exp.size() && i < cfg_got.size(); i++)
      check($sformatf("%s_cfg%0d", tag, i), {24'd0, cfg_got[i]}, {24'd0, cfg_exp[i]});
    cfg_got.delete();
    cfg_exp.delete();
  endtask

  initial begin
    int hr0, pend, k, nh;
    logic [1:0] zeros;
    reset = 1'b1; spi_csb = 1'b1; spi_clock = 1'b0; spi_mosi = 1'b0; err_clear = 1'b0;
    #32;
    check("rst_miso0", spi_miso0, 1'b0);
    check("rst_miso1", spi_miso1, 1'b0);
    check("rst_interruptB", interruptB, 1'b1);
    check("rst_hit_ready", hit_ready, 1'b0);
    check("rst_cfg_valid", cfg_valid, 1'b0);
    check("rst_cfg_data", cfg_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    #10 reset = 1'b0;
    #(2 * HALF);

    // No hit data: 32 SCK give eight fill bytes.
    start_xfer(); sck(32); end_xfer();
    check_bytes("idle", 8);
    check("idle_interruptB", interruptB, 1'b1);
    check("idle_hit_ready_cnt", hr_cnt, 0);
    check("idle_frame_err", frame_err, 1'b0);
    for (int i = 0; i < 4; i++) cfg_exp.push_back(8'h00);
    check_cfg("idle");

    // Two hit bytes read back while the master writes 5A, F0.
    push_hit(8'hA5); push_hit(8'h3C);
    #40;
    check("hits_interruptB_low", interruptB, 1'b0);
    push_mosi(8'h5A); push_mosi(8'hF0);
    hr0 = hr_cnt;
    start_xfer(); sck(16); end_xfer();
    check_bytes("hits", 4);
    check("hits_hit_ready_cnt", hr_cnt - hr0, 2);
    check("hits_interruptB_high", interruptB, 1'b1);
    check_cfg("mosi");

    // Abort after two SCK: the byte stays pending and the frame is flagged.
    push_hit(8'h77);
    hr0 = hr_cnt;
    start_xfer(); sck(2); end_xfer();
    check("abort_hit_ready_cnt", hr_cnt - hr0, 0);
    check("abort_frame_err", frame_err, 1'b1);
    check("abort_pending", hit_valid, 1'b1);
    start_xfer(); sck(8); end_xfer();
    check_bytes("resend", 2);
    check("resend_hit_ready_cnt", hr_cnt - hr0, 1);
    cfg_exp.push_back(8'h00);
    check_cfg("resend");

    // Random hit bursts and MOSI traffic against the queue model.
    for (int it = 0; it < 6; it++) begin
      nh = $urandom_range(0, 3);
      for (int j = 0; j < nh; j++) push_hit(8'($urandom));
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) push_mosi(8'($urandom));
      pend = model_q.size();
      hr0 = hr_cnt;
      #40;
      start_xfer(); sck(8 * k); end_xfer();
      check($sformatf("rnd%0d_hit_ready_cnt", it), hr_cnt - hr0, (pend < 2 * k) ? pend : 2 * k);
      check_bytes($sformatf("rnd%0d", it), 2 * k);
      check_cfg($sformatf("rnd%0d", it));
    end

    // Reset mid-byte, then a held-low csb must not restart the transfer.
    push_hit(8'h42);
    #40;
    hr0 = hr_cnt;
    start_xfer(); sck(2);
    #(HALF / 2);
    reset = 1'b1;
    #1;
    check("mid_rst_miso0", spi_miso0, 1'b0);
    check("mid_rst_miso1", spi_miso1, 1'b0);
    check("mid_rst_interruptB", interruptB, 1'b1);
    check("mid_rst_hit_ready", hit_ready, 1'b0);
    check("mid_rst_cfg_valid", cfg_valid, 1'b0);
    check("mid_rst_cfg_data", cfg_data, 8'h00);
    check("mid_rst_frame_err", frame_err, 1'b0);
    #29 reset = 1'b0;
    #(HALF);
    sck(4);
    zeros = 2'b00;
    for (int i = 2; i < pairs_q.size(); i++) zeros = zeros | pairs_q[i];
    check("held_csb_miso_quiet", zeros, 2'b00);
    end_xfer();
    check("mid_rst_hit_ready_cnt", hr_cnt - hr0, 0);
    check("mid_rst_pending", hit_valid, 1'b1);
    check("held_csb_frame_err", frame_err, 1'b0);
    cfg_got.delete();
    start_xfer(); sck(8); end_xfer();
    check_bytes("after_rst", 2);
    check("after_rst_hit_ready_cnt", hr_cnt - hr0, 1);
    cfg_got.delete();

    // err_clear with no concurrent set event.
    start_xfer(); sck(1); end_xfer();
    check("err_set", frame_err, 1'b1);
    err_clear = 1'b1;
    #10 err_clear = 1'b0;
    #10;
    check("err_cleared", frame_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/astropix_spi_responder.md
ASTROPIX_SPI_RESPONDER -- requirements
Module: astropix_spi_responder

Interface
REQ-001 SHALL have parameter CPOL, default 0, idle level of spi_clock.
REQ-002 SHALL have parameter CPHA, default 1; MISO changes on the leading edge, MOSI/MISO are sampled by the master on the trailing edge.
REQ-003 SHALL have parameter IDLE_BYTE, 8 bits, default 8'hBC, the byte sent when no hit data is pending.
REQ-004 SHALL have port clock, input, 1, the single system clock; all logic is in this domain.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports spi_csb, spi_clock and spi_mosi, each input, 1, asynchronous SPI lines from the master; spi_csb is active-low.
REQ-007 SHALL have ports spi_miso0 and spi_miso1, each output, 1; spi_miso0 carries the odd (higher) bit of each pair.
REQ-008 SHALL have port interruptB, output, 1, active-low "hit data pending".
REQ-009 SHALL have ports hit_data (input, 8), hit_valid (input, 1) and hit_ready (output, 1), forming a first-word-fall-through hit byte source.
REQ-010 SHALL have ports cfg_data (output, 8) and cfg_valid (output, 1), carrying received MOSI bytes.
REQ-011 SHALL have ports frame_err (output, 1, sticky) and err_clear (input, 1).

Function
REQ-012 SHALL pass spi_csb, spi_clock and spi_mosi through 2-flop synchronizers, then detect edges on the synchronized values with one extra register; clock SHALL run at ≥8x SCK.
REQ-013 SHALL implement states IDLE and SHIFT.
- IDLE→SHIFT on synchronized csb low.
- SHIFT→IDLE on synchronized csb high, from any sub-position.
REQ-014 In IDLE, SHALL hold pair_cnt=0 and rx_bit_cnt=0, drive both MISO lines 0, and keep hit_ready=0.
REQ-015 On each leading SCK edge in SHIFT with pair_cnt==0, SHALL latch tx_byte=hit_data and from_hit=1 if hit_valid, else tx_byte=IDLE_BYTE and from_hit=0.
REQ-016 On each leading edge, SHALL drive {spi_miso0,spi_miso1}=tx_byte[7-2*pair_cnt -: 2] (bits 7:6 first), then increment pair_cnt modulo 4.
REQ-017 SHALL pulse hit_ready for exactly one cycle on the leading edge that drives pair 3 when from_hit=1; that is the only consumption point.
REQ-018 A byte aborted by csb high before pair 3 SHALL NOT be consumed; it is resent whole at the next transaction.
REQ-019 On each trailing SCK edge in SHIFT, SHALL shift synchronized MOSI MSB-first into rx_shift and increment rx_bit_cnt modulo 8.
REQ-020 On the 8th trailing edge, SHALL present cfg_data = completed byte and pulse cfg_valid for 1 cycle, with latency ≤1 cycle after the edge is detected.
REQ-021 SHALL hold cfg_data stable until the next cfg_valid.
REQ-022 SHALL register interruptB = ~hit_valid, updated every cycle independent of csb.
REQ-023 SHALL set frame_err when csb rises with rx_bit_cnt≠0 or pair_cnt≠0.
REQ-024 err_clear SHALL clear frame_err; if a set event occurs in the same cycle, set wins.
REQ-025 SHALL ignore SCK edges detected while synchronized csb is high.

Reset
REQ-026 On reset, SHALL force state=IDLE, spi_miso0=0, spi_miso1=0, interruptB=1, hit_ready=0, cfg_valid=0, cfg_data=0, frame_err=0, all counters and shifts to 0, and synchronizers to csb=1 and sck=CPOL.
REQ-027 Reset mid-transaction SHALL abort without consuming a hit byte; after reset release, operation SHALL resume only on a new csb falling edge.

Structure
REQ-028 SHALL place the state enum and the default IDLE_BYTE value (8'hBC) in shared package astropix_spi_pkg, for use by both master and responder.
REQ-029 SHALL use one sub-module, spi_sync_edge, providing the 2-flop synchronizer plus rise/fall detect, instantiated three times.

Verification
REQ-030 Bench SHALL cover: hit_valid=0, csb low, 32 SCK -> MISO pairs decode to 8 bytes of 8'hBC; interruptB=1; no hit_ready.
REQ-031 Bench SHALL cover: hit FIFO holding 8'hA5 then 8'h3C -> first two bytes read A5, 3C, then BC; hit_ready pulses twice; interruptB goes 1 after the second pulse.
REQ-032 Bench SHALL cover: master writes 8'h5A, 8'hF0 on MOSI -> cfg_valid pulses twice with cfg_data 5A then F0.
REQ-033 Bench SHALL cover: hit 8'h77, csb raised after 2 SCK -> no hit_ready, frame_err=1; next transaction reads 77 from pair 0.
REQ-034 Bench SHALL cover: reset asserted mid-byte -> all outputs at reset values within 1 cycle; hit byte still pending; err_clear with no event clears frame_err.
